// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel input/output stages: widths, pipeline mode
// encodings and the byte-position state used while assembling a pixel.
package pixel_pkg;

  localparam int MAX_PIXEL_BITS  = 24;
  localparam int PIXEL_WIDTH_OUT = 8;

  localparam logic [1:0] MODE_GRAY_SOBEL   = 2'b00;
  localparam logic [1:0] MODE_SOBEL_DIRECT = 2'b01;
  localparam logic [1:0] MODE_GRAY         = 2'b10;
  localparam logic [1:0] MODE_BYPASS       = 2'b11;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } byte_state_t;

  // Only direct-Sobel mode carries one gray byte per pixel.
  function automatic logic is_one_byte(input logic [1:0] sel);
    return sel == MODE_SOBEL_DIRECT;
  endfunction

endpackage

// File: rtl/px_frame_counter.sv
// Pixel-in-frame counter: counts completed pixels, wraps after the last pixel
// of a frame and pulses frame_done_o on the cycle the last pixel is presented.
module px_frame_counter #(
  parameter int                     FRAME_CNT_W  = 16,
  parameter logic [FRAME_CNT_W-1:0] FRAME_PIXELS = 16'd19200
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic frame_done_o
);

  logic [FRAME_CNT_W-1:0] count;
  logic [FRAME_CNT_W-1:0] base;
  logic                   last;

  // A clear in the same cycle as an increment makes that pixel the first of the frame.
  always_comb begin
    base = clr_i ? '0 : count;
    last = (base == FRAME_PIXELS - FRAME_CNT_W'(1));
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      count        <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= inc_i && last;
      if (inc_i) begin
        count <= last ? '0 : base + FRAME_CNT_W'(1);
      end else if (clr_i) begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/pixel_byte_assembler.sv
// Assembles a strobed byte stream into 24-bit RGB or 8-bit gray pixels and
// presents each as a held word with a one-cycle ready pulse.
module pixel_byte_assembler
  import pixel_pkg::*;
#(
  parameter int                     FRAME_CNT_W  = 16,
  parameter logic [FRAME_CNT_W-1:0] FRAME_PIXELS = 16'd19200
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic [1:0]                select_i,
  input  logic                      sync_i,
  input  logic [7:0]                data_i,
  input  logic                      data_valid_i,
  input  logic                      err_clr_i,
  output logic [MAX_PIXEL_BITS-1:0] in_pixel_o,
  output logic                      px_rdy_o,
  output logic                      frame_done_o,
  output logic                      err_o,
  output logic [1:0]                byte_state_o
);

  localparam int HI_BITS = MAX_PIXEL_BITS - PIXEL_WIDTH_OUT;

  // Handshake: data_valid_i alone transfers a byte (no ready, no stall), and
  // px_rdy_o alone presents a pixel; the consumer must take every pulse.

  byte_state_t               byte_state;
  byte_state_t               state_next;
  byte_state_t               eff_state;
  logic                      mode_1b;
  logic                      one_byte;
  logic                      complete;
  logic [HI_BITS-1:0]        shift_reg;
  logic [MAX_PIXEL_BITS-1:0] word;

  assign byte_state_o = byte_state;

  // sync_i realigns before the byte of the same cycle is considered.
  always_comb begin
    eff_state  = sync_i ? B0 : byte_state;
    one_byte   = (eff_state == B0) ? is_one_byte(select_i) : mode_1b;
    complete   = data_valid_i && ((eff_state == B0 && one_byte) || eff_state == B2);
    word       = one_byte ? MAX_PIXEL_BITS'(data_i) : {shift_reg, data_i};
    state_next = eff_state;
    if (data_valid_i) begin
      case (eff_state)
        B0:      state_next = one_byte ? B0 : B1;
        B1:      state_next = B2;
        default: state_next = B0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      byte_state <= B0;
    end else begin
      byte_state <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      mode_1b    <= 1'b0;
      shift_reg  <= '0;
      in_pixel_o <= '0;
      px_rdy_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (data_valid_i && eff_state == B0) begin
        mode_1b                                   <= one_byte;
        shift_reg[HI_BITS-1 -: PIXEL_WIDTH_OUT]   <= data_i;
      end
      if (data_valid_i && eff_state == B1) begin
        shift_reg[PIXEL_WIDTH_OUT-1:0] <= data_i;
      end
      px_rdy_o <= complete;
      if (complete) begin
        in_pixel_o <= word;
      end
      if (sync_i && byte_state != B0) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

  px_frame_counter #(
    .FRAME_CNT_W  (FRAME_CNT_W),
    .FRAME_PIXELS (FRAME_PIXELS)
  ) u_frame_counter (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .clr_i        (sync_i),
    .inc_i        (complete),
    .frame_done_o (frame_done_o)
  );

endmodule

// File: tb/tb_pixel_byte_assembler.sv
// Bench for pixel_byte_assembler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_pixel_byte_assembler;

  localparam int         FP    = 4;
  localparam logic [1:0] SEL3  = 2'b11;
  localparam logic [1:0] SEL1  = 2'b01;

  // clock / reset
  logic        clk = 1'b0;
  logic        nreset_i;
  logic [1:0]  select_i;
  logic        sync_i;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic        err_clr_i;
  logic [23:0] in_pixel_o;
  logic        px_rdy_o;
  logic        frame_done_o;
  logic        err_o;
  logic [1:0]  byte_state_o;

  always #5 clk = ~clk;

  pixel_byte_assembler #(
    .FRAME_CNT_W  (16),
    .FRAME_PIXELS (16'(FP))
  ) dut (
    .clk_i        (clk),
    .nreset_i     (nreset_i),
    .select_i     (select_i),
    .sync_i       (sync_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .err_clr_i    (err_clr_i),
    .in_pixel_o   (in_pixel_o),
    .px_rdy_o     (px_rdy_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o),
    .byte_state_o (byte_state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: bytes of the pending pixel in a queue
  logic [7:0]  part_q[$];
  logic [23:0] exp_q[$];
  bit          m_one;
  int          m_cnt;
  logic [23:0] m_pixel;
  bit          m_rdy, m_done, m_err, m_err_set;

  always @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      part_q.delete();
      m_one = 0; m_cnt = 0; m_pixel = '0; m_rdy = 0; m_done = 0; m_err = 0;
    end else begin
      m_rdy = 0; m_done = 0; m_err_set = 0;
      if (sync_i) begin
        if (part_q.size() != 0) m_err_set = 1;
        part_q.delete();
        m_cnt = 0;
      end
      if (data_valid_i) begin
        if (part_q.size() == 0) m_one = (select_i == SEL1);
        part_q.push_back(data_i);
        if (part_q.size() == (m_one ? 1 : 3)) begin
          m_pixel = m_one ? {16'h0, part_q[0]} : {part_q[0], part_q[1], part_q[2]};
          exp_q.push_back(m_pixel);
          m_rdy = 1;
          m_cnt++;
          if (m_cnt == FP) begin
            m_done = 1;
            m_cnt = 0;
          end
          part_q.delete();
        end
      end
      if (m_err_set) m_err = 1;
      else if (err_clr_i) m_err = 0;
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (nreset_i && chk_en) begin
      check("px_rdy", {23'h0, px_rdy_o}, {23'h0, m_rdy});
      check("frame_done", {23'h0, frame_done_o}, {23'h0, m_done});
      check("err", {23'h0, err_o}, {23'h0, m_err});
      check("in_pixel", in_pixel_o, m_pixel);
      if (px_rdy_o) begin
        if (exp_q.size() == 0) check("unexpected_pulse", 24'h1, 24'h0);
        else check("pixel_order", in_pixel_o, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] s,
                     input logic sy, input logic cl);
    data_valid_i = v; data_i = d; select_i = s; sync_i = sy; err_clr_i = cl;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [1:0] s);
    repeat (n) cyc(1'b0, 8'($urandom_range(0, 255)), s, 1'b0, 1'b0);
  endtask

  initial begin
    nreset_i = 1'b0; select_i = SEL3; sync_i = 1'b0; data_i = 8'h0;
    data_valid_i = 1'b0; err_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_pixel", in_pixel_o, 24'h0);
    check("reset_rdy", {23'h0, px_rdy_o}, 24'h0);
    check("reset_done", {23'h0, frame_done_o}, 24'h0);
    check("reset_err", {23'h0, err_o}, 24'h0);
    check("reset_state", {22'h0, byte_state_o}, 24'h0);
    nreset_i = 1'b1;
    chk_en   = 1'b1;
    @(negedge clk);

    // RGB pixel, one cycle latency, held afterwards
    cyc(1, 8'h12, SEL3, 0, 0);
    cyc(1, 8'h34, SEL3, 0, 0);
    check("t1_no_early_pulse", {23'h0, px_rdy_o}, 24'h0);
    cyc(1, 8'h56, SEL3, 0, 0);
    check("t1_rdy", {23'h0, px_rdy_o}, 24'h1);
    check("t1_pixel", in_pixel_o, 24'h123456);
    check("t1_model", m_pixel, 24'h123456);
    idle(1, SEL3);
    check("t1_rdy_drop", {23'h0, px_rdy_o}, 24'h0);
    check("t1_hold", in_pixel_o, 24'h123456);

    // back-to-back gray bytes
    cyc(1, 8'hA0, SEL1, 0, 0);
    check("t2_pix0", in_pixel_o, 24'h0000A0);
    cyc(1, 8'hA1, SEL1, 0, 0);
    check("t2_pix1", in_pixel_o, 24'h0000A1);
    cyc(1, 8'hA2, SEL1, 0, 0);
    check("t2_pix2", in_pixel_o, 24'h0000A2);
    check("t2_rdy", {23'h0, px_rdy_o}, 24'h1);
    check("t2_frame_done_4th", {23'h0, frame_done_o}, 24'h1);

    // idle gaps, select change mid-pixel ignored
    cyc(1, 8'hFF, SEL3, 0, 0);
    idle(2, SEL1);
    cyc(1, 8'h00, SEL1, 0, 0);
    check("t3_no_pulse_mid", {23'h0, px_rdy_o}, 24'h0);
    idle(5, SEL1);
    cyc(1, 8'h80, SEL1, 0, 0);
    check("t3_pixel", in_pixel_o, 24'hFF0080);
    check("t3_rdy", {23'h0, px_rdy_o}, 24'h1);

    // sync with partial pixel pending
    cyc(1, 8'h11, SEL3, 0, 0);
    cyc(1, 8'h22, SEL3, 0, 0);
    cyc(1, 8'h33, SEL3, 1, 0);
    check("t4_no_pulse", {23'h0, px_rdy_o}, 24'h0);
    check("t4_err_set", {23'h0, err_o}, 24'h1);
    cyc(1, 8'h44, SEL3, 0, 0);
    cyc(1, 8'h55, SEL3, 0, 0);
    check("t4_pixel", in_pixel_o, 24'h334455);
    check("t4_err_sticky", {23'h0, err_o}, 24'h1);
    cyc(0, 8'h00, SEL3, 0, 1);
    check("t4_err_clr", {23'h0, err_o}, 24'h0);

    // frame wrap every FP pixels
    cyc(0, 8'h00, SEL1, 1, 0);
    check("t5_sync_no_err", {23'h0, err_o}, 24'h0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1, 8'(i), SEL1, 0, 0);
      check($sformatf("t5_done_px%0d", i), {23'h0, frame_done_o},
            (i == 4 || i == 8) ? 24'h1 : 24'h0);
    end

    // asynchronous reset mid-pixel
    cyc(1, 8'h77, SEL3, 0, 0);
    #2 nreset_i = 1'b0;
    #1;
    check("t6_pixel_zero", in_pixel_o, 24'h0);
    check("t6_rdy_zero", {23'h0, px_rdy_o}, 24'h0);
    check("t6_state_b0", {22'h0, byte_state_o}, 24'h0);
    exp_q.delete();
    @(negedge clk);
    nreset_i = 1'b1;
    cyc(1, 8'h01, SEL3, 0, 0);
    cyc(1, 8'h02, SEL3, 0, 0);
    cyc(1, 8'h03, SEL3, 0, 0);
    check("t6_pixel", in_pixel_o, 24'h010203);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 2) == 0) ? SEL1 : 2'($urandom_range(0, 3));
      cyc(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)), s,
          ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(3, SEL3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
